// File: rtl/alu_slice_unit.sv
// ----------------------------------------------------------------------------
// alu_slice_unit
//
// Registered ripple-carry ALU slice array. Each bit is a full adder
// (add_1bit) feeding a 5-way result selector (mux_5bit). It supports ADD, SUB,
// XOR, SLT and bitwise AND ("multiply"). The result and the MSB carry are
// registered, so latency is one cycle and a new operation can start every
// cycle.
//
// Parameters:
//   WIDTH      operand width in bits, 1..32 (WIDTH=1 is a single bit slice)
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-high reset
//   in_valid   a/b/cin/cntrl are valid this cycle
//   a, b       operands
//   cin        carry into bit 0 (a caller doing SUB or SLT must drive 1 here)
//   cntrl      0 ADD, 1 SUB, 2 XOR, 3 SLT, 4 AND, 5..7 zero
//   out        registered result
//   cout       registered carry out of the MSB adder
//   out_valid  high the cycle after an accepted operation
//
// Optional feature (macro ALU_SLICE_FLAGS_EN):
//   zero       registered: the result is all zeros
//   overflow   registered: signed overflow, for ADD/SUB only (0 otherwise)
// ----------------------------------------------------------------------------
module alu_slice_unit #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic [2:0]       cntrl,
   output logic [WIDTH-1:0] out,
   output logic             cout,
   output logic             out_valid
`ifdef ALU_SLICE_FLAGS_EN
   ,
   output logic             zero,
   output logic             overflow
`endif
);

   // Full adder. Returns {carry, sum}.
   function automatic logic [1:0] add_1bit(input logic x, input logic y, input logic c);
      logic s;
      logic co;
      s  = x ^ y ^ c;
      co = (x & y) | (x & c) | (y & c);
      return {co, s};
   endfunction

   // Per-bit result selector over the five result sources.
   function automatic logic mux_5bit(input logic [2:0] sel,
                                     input logic       sum_bit,
                                     input logic       xor_bit,
                                     input logic       slt_bit,
                                     input logic       and_bit);
      logic r;
      case (sel)
         3'd0, 3'd1: r = sum_bit;
         3'd2:       r = xor_bit;
         3'd3:       r = slt_bit;
         3'd4:       r = and_bit;
         default:    r = 1'b0;
      endcase
      return r;
   endfunction

   logic [WIDTH-1:0] bin;
   logic [WIDTH-1:0] sum;
   logic             carry_msb_in;
   logic             carry_out;
   logic             ovf;
   logic             slt_bit;
   logic [WIDTH-1:0] next_out;

   // B is inverted for every odd operation code (SUB, SLT, and the unused 5/7).
   assign bin = b ^ {WIDTH{cntrl[0]}};

   // Ripple chain. The carry vector lives inside the block so the chain is
   // evaluated in a single ordered pass.
   // NOTE: combinational blocks use blocking '=' so each stage sees the carry
   // just computed; every output gets a default first so no latch is inferred.
   always_comb begin : adder_chain
      logic [WIDTH:0] c;
      logic [1:0]     fa;
      c            = '0;
      sum          = '0;
      fa           = '0;
      c[0]         = cin;
      for (int i = 0; i < WIDTH; i++) begin
         fa       = add_1bit(a[i], bin[i], c[i]);
         sum[i]   = fa[0];
         c[i+1]   = fa[1];
      end
      carry_msb_in = c[WIDTH-1];
      carry_out    = c[WIDTH];
   end

   // Signed overflow: carry into the MSB disagrees with carry out of it.
   assign ovf     = carry_msb_in ^ carry_out;
   assign slt_bit = sum[WIDTH-1] ^ ovf;

   always_comb begin
      next_out = '0;
      for (int i = 0; i < WIDTH; i++) begin
         next_out[i] = mux_5bit(cntrl, sum[i], a[i] ^ b[i],
                                (i == 0) ? slt_bit : 1'b0, a[i] & b[i]);
      end
   end

   // NOTE: sequential state uses non-blocking '<=' so all registers sample
   // the same pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         out       <= '0;
         cout      <= 1'b0;
         out_valid <= 1'b0;
      end else if (in_valid) begin
         out       <= next_out;
         cout      <= carry_out;
         out_valid <= 1'b1;
      end else begin
         // Result and carry hold; only the valid strobe drops.
         out_valid <= 1'b0;
      end
   end

`ifdef ALU_SLICE_FLAGS_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         zero     <= 1'b0;
         overflow <= 1'b0;
      end else if (in_valid) begin
         zero     <= (next_out == '0);
         overflow <= (cntrl[2:1] == 2'b00) ? ovf : 1'b0;
      end
   end
`endif

endmodule

// File: tb/tb_alu_slice_unit.sv
// ----------------------------------------------------------------------------
// tb_alu_slice_unit
//
// Drives a WIDTH=1 and a WIDTH=4 instance of alu_slice_unit and compares them
// against a behavioural model that uses whole-word arithmetic: the sum and carry
// come from one wide addition, and signed overflow comes from operand and
// result sign bits.
// ----------------------------------------------------------------------------
module tb_alu_slice_unit;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   // WIDTH=4 instance signals
   logic       v4, cin4, ov4_o, cout4, ovalid4;
   logic [3:0] a4, b4, out4;
   logic [2:0] op4;
   // WIDTH=1 instance signals
   logic       v1, cin1, cout1, ovalid1;
   logic [0:0] a1, b1, out1;
   logic [2:0] op1;
`ifdef ALU_SLICE_FLAGS_EN
   logic       zero4, over4, zero1, over1;
`endif

   int n_vec = 0;
   int n_err = 0;

   alu_slice_unit #(.WIDTH(4)) u_dut4 (
      .clk(clk), .reset(reset), .in_valid(v4), .a(a4), .b(b4), .cin(cin4),
      .cntrl(op4), .out(out4), .cout(cout4), .out_valid(ovalid4)
`ifdef ALU_SLICE_FLAGS_EN
      , .zero(zero4), .overflow(over4)
`endif
   );

   alu_slice_unit #(.WIDTH(1)) u_dut1 (
      .clk(clk), .reset(reset), .in_valid(v1), .a(a1), .b(b1), .cin(cin1),
      .cntrl(op1), .out(out1), .cout(cout1), .out_valid(ovalid1)
`ifdef ALU_SLICE_FLAGS_EN
      , .zero(zero1), .overflow(over1)
`endif
   );

   // Reference model: whole-word arithmetic modulo 2^w.
   function automatic void ref_model(input int w, input logic [31:0] a, input logic [31:0] b,
                                     input logic cin, input logic [2:0] op,
                                     output logic [31:0] r, output logic co,
                                     output logic ovf_flag, output logic zf);
      logic [31:0] mask, bin, sum;
      logic [32:0] total;
      logic        ov;
      mask  = (w == 32) ? 32'hFFFF_FFFF : ((32'h1 << w) - 32'h1);
      bin   = (op[0] ? ~b : b) & mask;
      total = {1'b0, a & mask} + {1'b0, bin} + {32'b0, cin};
      sum   = total[31:0] & mask;
      co    = total[w];
      ov    = (a[w-1] == bin[w-1]) && (sum[w-1] != a[w-1]);
      case (op)
         3'd0, 3'd1: r = sum;
         3'd2:       r = (a ^ b) & mask;
         3'd3:       r = {31'b0, sum[w-1] ^ ov};
         3'd4:       r = a & b & mask;
         default:    r = 32'h0;
      endcase
      ovf_flag = (op <= 3'd1) ? ov : 1'b0;
      zf       = (r == 32'h0);
   endfunction

   // Apply one 4-bit cycle of stimulus; return sampled 1 time unit after the edge.
   task automatic drive4(input logic v, input logic [3:0] a, input logic [3:0] b,
                         input logic cin, input logic [2:0] op);
      @(negedge clk);
      v4 = v; a4 = a; b4 = b; cin4 = cin; op4 = op;
      @(posedge clk);
      #1;
   endtask

   task automatic drive1(input logic v, input logic a, input logic b,
                         input logic cin, input logic [2:0] op);
      @(negedge clk);
      v1 = v; a1 = a; b1 = b; cin1 = cin; op1 = op;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      logic [31:0] r; logic co, ovf, zf;
      // Load a nonzero result first so the reset has something to clear.
      reset = 1'b0;
      drive4(1'b1, 4'h5, 4'h6, 1'b1, 3'd0);
      ref_model(4, 32'h5, 32'h6, 1'b1, 3'd0, r, co, ovf, zf);
      n_vec++;
      if (out4 !== r[3:0] || ovalid4 !== 1'b1) begin
         n_err++;
         $display("FAIL pre_reset_load: out=%h valid=%b, want out=%h valid=1", out4, ovalid4, r[3:0]);
      end
      // Reset together with in_valid: reset must win.
      @(negedge clk);
      reset = 1'b1; v4 = 1'b1; a4 = 4'hF; b4 = 4'hF; cin4 = 1'b1; op4 = 3'd0;
      v1 = 1'b1; a1 = 1'b1; b1 = 1'b1; cin1 = 1'b1; op1 = 3'd0;
      @(posedge clk);
      #1;
      n_vec++;
      if (out4 !== 4'h0 || cout4 !== 1'b0 || ovalid4 !== 1'b0) begin
         n_err++;
         $display("FAIL reset4: out=%h cout=%b valid=%b, want 0/0/0", out4, cout4, ovalid4);
      end
      n_vec++;
      if (out1 !== 1'b0 || cout1 !== 1'b0 || ovalid1 !== 1'b0) begin
         n_err++;
         $display("FAIL reset1: out=%b cout=%b valid=%b, want 0/0/0", out1, cout1, ovalid1);
      end
`ifdef ALU_SLICE_FLAGS_EN
      n_vec++;
      if (zero4 !== 1'b0 || over4 !== 1'b0) begin
         n_err++;
         $display("FAIL reset_flags: zero=%b overflow=%b, want 0/0", zero4, over4);
      end
`endif
      @(negedge clk);
      reset = 1'b0; v4 = 1'b0; v1 = 1'b0;
   endtask

   task automatic test_single_slice();
      logic [1:0] steps [4] = '{2'b10, 2'b00, 2'b01, 2'b11};   // {a, cin}
      logic       exp_out [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
      logic       exp_co  [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
      for (int i = 0; i < 4; i++) begin
         drive1(1'b1, steps[i][1], 1'b1, steps[i][0], 3'd1);
         n_vec++;
         if (out1 !== exp_out[i] || cout1 !== exp_co[i] || ovalid1 !== 1'b1) begin
            n_err++;
            $display("FAIL slice_step%0d: out=%b cout=%b valid=%b, want %b/%b/1",
                     i, out1, cout1, ovalid1, exp_out[i], exp_co[i]);
         end
      end
      @(negedge clk);
      v1 = 1'b0;
   endtask

   task automatic test_add_wrap();
      drive4(1'b1, 4'hF, 4'h1, 1'b0, 3'd0);
      n_vec++;
      if (out4 !== 4'h0 || cout4 !== 1'b1 || ovalid4 !== 1'b1) begin
         n_err++;
         $display("FAIL add_wrap: out=%h cout=%b valid=%b, want 0/1/1", out4, cout4, ovalid4);
      end
`ifdef ALU_SLICE_FLAGS_EN
      n_vec++;
      if (zero4 !== 1'b1 || over4 !== 1'b0) begin
         n_err++;
         $display("FAIL add_wrap_flags: zero=%b overflow=%b, want 1/0", zero4, over4);
      end
`endif
   endtask

   task automatic test_slt();
      drive4(1'b1, 4'h3, 4'h5, 1'b1, 3'd3);
      n_vec++;
      if (out4 !== 4'h1) begin
         n_err++;
         $display("FAIL slt_3_5: out=%h, want 1", out4);
      end
      drive4(1'b1, 4'h7, 4'h8, 1'b1, 3'd3);
      n_vec++;
      if (out4 !== 4'h0) begin
         n_err++;
         $display("FAIL slt_7_m8: out=%h, want 0", out4);
      end
   endtask

   task automatic test_bitwise();
      logic [2:0] ops [3] = '{3'd2, 3'd4, 3'd6};
      logic [3:0] exp [3] = '{4'hC, 4'h2, 4'h0};
      for (int i = 0; i < 3; i++) begin
         drive4(1'b1, 4'hA, 4'h6, 1'b0, ops[i]);
         n_vec++;
         if (out4 !== exp[i] || ovalid4 !== 1'b1) begin
            n_err++;
            $display("FAIL bitwise_op%0d: out=%h valid=%b, want %h/1", ops[i], out4, ovalid4, exp[i]);
         end
      end
   endtask

   task automatic test_hold();
      drive4(1'b1, 4'h9, 4'h4, 1'b0, 3'd0);          // 9+4 = D, no carry
      n_vec++;
      if (out4 !== 4'hD || cout4 !== 1'b0 || ovalid4 !== 1'b1) begin
         n_err++;
         $display("FAIL hold_load: out=%h cout=%b valid=%b, want D/0/1", out4, cout4, ovalid4);
      end
      drive4(1'b0, 4'hF, 4'hF, 1'b1, 3'd0);          // would give F with carry
      n_vec++;
      if (out4 !== 4'hD || cout4 !== 1'b0 || ovalid4 !== 1'b0) begin
         n_err++;
         $display("FAIL hold_idle: out=%h cout=%b valid=%b, want D/0/0", out4, cout4, ovalid4);
      end
   endtask

   // Back-to-back random traffic with random idle cycles on both instances.
   task automatic test_back_to_back();
      logic [31:0] r; logic co, ovf, zf;
      logic [3:0]  held4   = out4;
      logic        heldc4  = cout4;
      logic        held1   = out1;
      logic        heldc1  = cout1;
`ifdef ALU_SLICE_FLAGS_EN
      logic        heldz4  = zero4;
      logic        heldo4  = over4;
`endif
      for (int n = 0; n < 300; n++) begin
         logic       v, vv;
         logic [3:0] a, b;
         logic [2:0] op, op_1;
         logic       c, a_1, b_1, c_1;
         v  = ($urandom_range(0, 3) != 0);
         a  = 4'($urandom);  b = 4'($urandom);
         c  = 1'($urandom);  op = 3'($urandom);
         vv = ($urandom_range(0, 3) != 0);
         a_1 = 1'($urandom); b_1 = 1'($urandom); c_1 = 1'($urandom); op_1 = 3'($urandom);
         @(negedge clk);
         v4 = v;  a4 = a;  b4 = b;  cin4 = c;  op4 = op;
         v1 = vv; a1 = a_1; b1 = b_1; cin1 = c_1; op1 = op_1;
         @(posedge clk);
         #1;
         if (v) begin
            ref_model(4, {28'b0, a}, {28'b0, b}, c, op, r, co, ovf, zf);
            held4 = r[3:0]; heldc4 = co;
`ifdef ALU_SLICE_FLAGS_EN
            heldz4 = zf; heldo4 = ovf;
`endif
         end
         n_vec++;
         if (out4 !== held4 || cout4 !== heldc4 || ovalid4 !== v) begin
            n_err++;
            $display("FAIL rand4[%0d] op=%0d a=%h b=%h cin=%b v=%b: out=%h cout=%b valid=%b, want %h/%b/%b",
                     n, op, a, b, c, v, out4, cout4, ovalid4, held4, heldc4, v);
         end
`ifdef ALU_SLICE_FLAGS_EN
         n_vec++;
         if (zero4 !== heldz4 || over4 !== heldo4) begin
            n_err++;
            $display("FAIL rand4_flags[%0d]: zero=%b overflow=%b, want %b/%b",
                     n, zero4, over4, heldz4, heldo4);
         end
`endif
         if (vv) begin
            ref_model(1, {31'b0, a_1}, {31'b0, b_1}, c_1, op_1, r, co, ovf, zf);
            held1 = r[0]; heldc1 = co;
         end
         n_vec++;
         if (out1 !== held1 || cout1 !== heldc1 || ovalid1 !== vv) begin
            n_err++;
            $display("FAIL rand1[%0d] op=%0d a=%b b=%b cin=%b v=%b: out=%b cout=%b valid=%b, want %b/%b/%b",
                     n, op_1, a_1, b_1, c_1, vv, out1, cout1, ovalid1, held1, heldc1, vv);
         end
      end
      @(negedge clk);
      v4 = 1'b0; v1 = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      v4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0; op4 = '0;
      v1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0; op1 = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      test_reset();
      test_single_slice();
      test_add_wrap();
      test_slt();
      test_bitwise();
      test_hold();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   // Guard against a stalled run.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, want completion");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/alu_slice_unit.md
Name: alu_slice_unit

Overview:
- Registered ripple ALU datapath built from per-bit full adders (add_1bit function) and per-bit 5-way result selectors (mux_5bit function).
- Supports add, subtract, XOR, set-less-than and bitwise multiply (AND).
- Sits in the MIPS ALU datapath as the slice array under the ALU control decoder.
- Results and carry are registered with one-cycle latency.

Parameters:
- WIDTH, 4, operand width in bits; legal values 1..32. The WIDTH=1 case is the single bit slice.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  operands and control valid this cycle
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- cin  input  1  carry into bit 0
- cntrl  input  3  operation select
- out  output  WIDTH  registered result
- cout  output  1  registered carry out of the MSB adder
- out_valid  output  1  registered result valid

Behaviour:
- One clock; reset is synchronous and active-high.
- When reset is high at a clk edge: out=0, cout=0, out_valid=0, and flags (if compiled in) are 0. Reset wins over in_valid in the same cycle.
- Operand B conditioning: bin[i] = b[i] XOR cntrl[0]. B is inverted for every odd cntrl value.
- Adder chain:
  - Full adder per bit: sum = a XOR bin XOR c; carry = majority(a, bin, c).
  - c[0] = cin.
  - Ripple carry to the MSB; cout = carry out of bit WIDTH-1.
  - cin is never forced. A true two's-complement subtract requires cin=1 from the caller.
- Result selection per cntrl:
  - 0 ADD: out = sum.
  - 1 SUB: out = sum, computed with inverted B.
  - 2 XOR: out = a XOR b, using raw b, not bin.
  - 3 SLT: out[0] = sum[WIDTH-1] XOR ovf, where ovf = carry into MSB XOR cout. Other bits are 0.
  - 4 MUL: out = a AND b, bitwise.
  - 5, 6, 7: out = 0.
- cout is always registered from the adder chain, regardless of cntrl.
- Registering:
  - When in_valid=1 at a clk edge: out, cout and out_valid=1 update.
  - When in_valid=0: out and cout hold their previous values and out_valid=0.
- Latency: exactly 1 cycle. Full throughput: a new operation can be accepted every cycle.
- No back-pressure and no internal state beyond the output registers.
- Arithmetic is modulo 2^WIDTH; overflow wraps silently unless the flags feature is enabled.

Optional Feature:
- Macro: ALU_SLICE_FLAGS_EN.
- When defined, two additional output ports, each 1 bit, are registered with out and reset to 0:
  - zero = 1 when the next out value is all zeros.
  - overflow = ovf. It is valid for cntrl 0/1 and 0 for all other codes.
- When not defined, these ports do not exist and no flag logic is built.

Test Plan:
- WIDTH=1, single-slice adder sequence, cntrl=1, b=1, each step held for 1 cycle with in_valid=1:
  - a=1, cin=0 -> out=1, cout=0
  - a=0, cin=0 -> out=0, cout=0
  - a=0, cin=1 -> out=1, cout=0
  - a=1, cin=1 -> out=0, cout=1
- WIDTH=4, cntrl=0, a=4'hF, b=4'h1, cin=0 -> next cycle out=4'h0, cout=1, out_valid=1. With flags enabled: zero=1, overflow=0.
- WIDTH=4, cntrl=3, cin=1:
  - a=4'h3, b=4'h5 -> out=4'h1
  - a=4'h7, b=4'h8 (signed 7 < -8 is false, overflow path) -> out=4'h0
- WIDTH=4, bitwise ops:
  - cntrl=2, a=4'hA, b=4'h6 -> out=4'hC
  - cntrl=4, same operands -> out=4'h2
  - cntrl=6 -> out=4'h0
- Reset and hold, WIDTH=4:
  - Assert reset together with in_valid=1 -> out=0, cout=0, out_valid=0 next cycle.
  - After reset, send one op, then in_valid=0 -> out holds and out_valid drops to 0.
